ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/ifetch_ctrl.sv | 123 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch front end: the fetch FSM state
// encoding and the {pc, instr} entry held in the fetch buffer.
// Entry fields are sized for the widest supported configuration; narrower
// instances zero-extend on write and truncate on read.
package ifetch_pkg;

    localparam int MAX_ADDR_W = 32;
    localparam int MAX_BIT_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [MAX_BIT_W-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer of {pc, instr}. Push and pop in the same cycle
// keep the count unchanged. Flush empties the buffer and wins over both.
// The head reads as zero while the buffer is empty.
module fetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem_reg [2];
    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;
    logic         do_push;
    logic         do_pop;
    logic [1:0]   wr_en;

    assign do_pop  = pop && (count_reg != 2'd0);
    // When full, a push is only legal because the simultaneous pop frees
    // the slot the write pointer is already sitting on.
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wen
            assign wr_en[gi] = do_push && (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            if (do_push && !do_pop)
                count_reg <= count_reg + 2'd1;
            else if (do_pop && !do_push)
                count_reg <= count_reg - 2'd1;
        end
    end

    // Entry storage; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < 2; i++)
                if (wr_en[i]) mem_reg[i] <= wr_entry;
        end
    end

    assign head  = (count_reg != 2'd0) ? mem_reg[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: drives a combinational-read instruction
// memory from the fetch PC and buffers returned words for decode.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to trap misaligned
// redirects (adds the fault port and FAULT state); otherwise redirect
// targets have their two low bits forced to zero.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          BIT_WIDTH  = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [BIT_WIDTH-1:0]  imem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_WIDTH-1:0]  out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic                  fault
`endif
);

    fetch_state_t          state_reg, state_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic                  redirect_take;
    logic                  misaligned;
    logic                  push;
    logic                  pop;
    logic [1:0]            count;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;
    logic                  unused_head;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_reg;

    // Once faulted, redirects are ignored until reset.
    assign redirect_take = redirect_valid && (state_reg != ST_FAULT);
    assign misaligned    = redirect_take && (redirect_pc[1:0] != 2'b00);

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            fault_reg <= 1'b0;
        else if (misaligned)
            fault_reg <= 1'b1;
    end

    assign fault = fault_reg;
`else
    logic unused_redirect_lsb;

    assign redirect_take       = redirect_valid;
    assign misaligned          = 1'b0;
    assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

    // A redirect flushes the buffer, so nothing may be pushed or popped
    // in that same cycle.
    assign pop  = out_valid && out_ready && !redirect_take;
    assign push = (state_reg == ST_FETCH) && !redirect_take &&
                  ((count != 2'd2) || pop);

    // Next FSM state and next fetch PC.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (fetch_en)  state_next = ST_FETCH;
            ST_FETCH: if (!fetch_en) state_next = ST_IDLE;
            default:  state_next = state_reg;
        endcase
        if (misaligned) state_next = ST_FAULT;

        pc_next = pc_reg;
        if (redirect_take && !misaligned)
            pc_next = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        else if (push)
            pc_next = pc_reg + ADDR_WIDTH'(4);
    end

    // State and PC registers; PC wraps naturally at 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= ADDR_WIDTH'(RESET_PC);
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Pack the current fetch into a buffer entry.
    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = MAX_ADDR_W'(pc_reg);
        wr_entry.instr = MAX_BIT_W'(imem_data);
    end

    fetch_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_take),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign imem_addr   = pc_reg;
    assign out_valid   = (count != 2'd0);
    assign out_pc      = head.pc[ADDR_WIDTH-1:0];
    assign out_instr   = head.instr[BIT_WIDTH-1:0];
    assign unused_head = ^head;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed scenarios followed by randomized
// traffic, all checked every cycle against a queue-based reference model.
// Define IFETCH_ALIGN_CHECK_EN to also exercise the misaligned-redirect trap.
module tb_ifetch_ctrl;

    localparam int AW  = 10;
    localparam int BW  = 32;
    localparam int RPC = 0;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] imem_addr;
    logic [BW-1:0] imem_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_instr;
    logic [AW-1:0] out_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic          fault;
`endif

    always #5 clk = ~clk;

    logic [BW-1:0] mem [256];
    assign imem_data = mem[imem_addr[AW-1:2]];

    ifetch_ctrl #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .fault          (fault)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: fetch PC, whether fetching runs, fault flag, and
    // the buffered {pc, instr} words as a plain queue.
    typedef struct {
        int          pc;
        logic [31:0] instr;
    } ent_t;

    ent_t m_q[$];
    int   m_pc;
    bit   m_run;
    bit   m_fault;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the
    // edge, then compare every observable output against it.
    task automatic step();
        bit   pop_m;
        bit   push_m;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_pc    = RPC;
            m_run   = 1'b0;
            m_fault = 1'b0;
        end else if (redirect_valid && !m_fault) begin
            m_q.delete();
            if (ALIGN_ON && (redirect_pc % 4 != 0))
                m_fault = 1'b1;
            else
                m_pc = int'(redirect_pc) / 4 * 4;
            m_run = fetch_en;
        end else begin
            pop_m    = (m_q.size() > 0) && out_ready;
            push_m   = m_run && !m_fault && ((m_q.size() < 2) || pop_m);
            e.pc     = m_pc;
            e.instr  = mem[m_pc / 4];
            if (pop_m) begin
                $display("txn pc=%03h instr=%08h", m_q[0].pc, m_q[0].instr);
                void'(m_q.pop_front());
            end
            if (push_m) begin
                m_q.push_back(e);
                m_pc = (m_pc + 4) % (1 << AW);
            end
            m_run = fetch_en;
        end
        #1;
        check("out_valid", out_valid, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_instr", out_instr, m_q[0].instr);
        end
        check("imem_addr", imem_addr, m_pc);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("fault", fault, m_fault);
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [AW-1:0] frozen;

        for (int k = 0; k < 256; k++) mem[k] = 32'h1000 + k;
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b0;
        steps(2);
        check("rst_valid", out_valid, 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", out_instr, 0);
        check("rst_addr", imem_addr, RPC);

        // Streaming with decode always ready.
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            check("seq_pc", out_pc, i * 4);
            check("seq_instr", out_instr, 32'h1000 + i);
        end

        // Backpressure straight after the first fetch.
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        steps(2);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_addr", imem_addr, 8);
            check("bp_pc", out_pc, 0);
        end
        out_ready = 1'b1;
        step(); check("rel_pc4", out_pc, 4);
        step(); check("rel_pc8", out_pc, 8);

        // Redirect while the buffer is full.
        out_ready = 1'b0;
        steps(2);
        check("full_valid", out_valid, 1);
        redirect_valid = 1'b1; redirect_pc = 10'h040;
        step(); check("redir_flush", out_valid, 0);
        redirect_valid = 1'b0; out_ready = 1'b1;
        step(); check("redir_pc40", out_pc, 10'h040);
        step(); check("redir_pc44", out_pc, 10'h044);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 10'h3FC;
        step();
        redirect_valid = 1'b0;
        step(); check("wrap_3fc", out_pc, 10'h3FC);
        step(); check("wrap_000", out_pc, 10'h000);

        // Reset wins over a simultaneous redirect with the buffer full.
        out_ready = 1'b0;
        steps(2);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h080;
        step();
        check("rstp_valid", out_valid, 0);
        check("rstp_addr", imem_addr, RPC);
        check("rstp_pc", out_pc, 0);
        check("rstp_instr", out_instr, 0);
        rst = 1'b0; redirect_valid = 1'b0;

        // Randomized traffic.
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            fetch_en       = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = AW'($urandom);
            if (ALIGN_ON) redirect_pc[1:0] = 2'b00;
            step();
        end
        rst = 1'b0; redirect_valid = 1'b0;

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned redirect traps and freezes fetching until reset.
        rst = 1'b1; step(); rst = 1'b0;
        fetch_en = 1'b1; out_ready = 1'b0;
        steps(3);
        redirect_valid = 1'b1; redirect_pc = 10'h042;
        frozen = imem_addr;
        step();
        check("flt_set", fault, 1);
        check("flt_valid", out_valid, 0);
        redirect_pc = 10'h100; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("flt_addr", imem_addr, frozen);
        end
        redirect_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("flt_clear", fault, 0);
`else
        frozen = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
